// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core.
// Registers decode controls, operands, register addresses and the immediate
// for EX; detects load-use hazards (combinational stall to PC and IF/ID) and
// inserts bubbles on stall or branch flush. A saturating counter tracks how
// many real instructions were replaced by bubbles.
module id_ex_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   d_valid,
    input  logic                   d_jump,
    input  logic                   d_memtoReg,
    input  logic                   d_memWrite,
    input  logic                   d_ALU_src,
    input  logic                   d_reg_dest,
    input  logic                   d_reg_write,
    input  logic                   d_branch,
    input  logic [2:0]             d_ALU_control,
    input  logic [DATA_W-1:0]      d_rd1,
    input  logic [DATA_W-1:0]      d_rd2,
    input  logic [REG_AW-1:0]      d_rs,
    input  logic [REG_AW-1:0]      d_rt,
    input  logic [REG_AW-1:0]      d_rd,
    input  logic [DATA_W-1:0]      d_imm,
    input  logic                   flush_i,
    output logic                   e_valid,
    output logic                   e_jump,
    output logic                   e_memtoReg,
    output logic                   e_memWrite,
    output logic                   e_ALU_src,
    output logic                   e_reg_dest,
    output logic                   e_reg_write,
    output logic                   e_branch,
    output logic [2:0]             e_ALU_control,
    output logic [DATA_W-1:0]      e_rd1,
    output logic [DATA_W-1:0]      e_rd2,
    output logic [DATA_W-1:0]      e_imm,
    output logic [REG_AW-1:0]      e_rs,
    output logic [REG_AW-1:0]      e_rt,
    output logic [REG_AW-1:0]      e_rd,
    output logic                   stall_o,
    output logic [STALL_CNT_W-1:0] bubble_cnt
);

    // ALU op carried by a bubble (and after reset): harmless add.
    localparam logic [2:0] ALU_ADD = 3'b010;

    logic load_in_ex_s;
    logic uses_rt_s;
    logic hazard_s;
    logic bubble_s;
    logic count_s;

    // Load-use hazard detection. memtoReg alone is not a load because sw also
    // asserts it; a real load must also write the register file.
    always_comb begin
        load_in_ex_s = 1'b0;
        uses_rt_s    = 1'b0;
        hazard_s     = 1'b0;
        bubble_s     = 1'b0;
        count_s      = 1'b0;
        load_in_ex_s = e_valid & e_memtoReg & e_reg_write;
        uses_rt_s    = ~d_ALU_src | d_memWrite;
        if (load_in_ex_s && d_valid && (e_rt != {REG_AW{1'b0}}) &&
            ((e_rt == d_rs) || (uses_rt_s && (e_rt == d_rt)))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        bubble_s = flush_i | hazard_s;
        // Only a real instruction replaced by a bubble is counted.
        count_s  = bubble_s & d_valid;
    end

    // Flush takes priority: a squashed instruction must not also hold PC.
    assign stall_o = hazard_s & ~flush_i;

    // Control half of the pipeline register: bubble on flush/hazard, else pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid       <= 1'b0;
            e_jump        <= 1'b0;
            e_memtoReg    <= 1'b0;
            e_memWrite    <= 1'b0;
            e_ALU_src     <= 1'b0;
            e_reg_dest    <= 1'b0;
            e_reg_write   <= 1'b0;
            e_branch      <= 1'b0;
            e_ALU_control <= ALU_ADD;
        end else if (bubble_s) begin
            e_valid       <= 1'b0;
            e_jump        <= 1'b0;
            e_memtoReg    <= 1'b0;
            e_memWrite    <= 1'b0;
            e_ALU_src     <= 1'b0;
            e_reg_dest    <= 1'b0;
            e_reg_write   <= 1'b0;
            e_branch      <= 1'b0;
            e_ALU_control <= ALU_ADD;
        end else begin
            e_valid       <= d_valid;
            e_jump        <= d_jump;
            e_memtoReg    <= d_memtoReg;
            e_memWrite    <= d_memWrite;
            e_ALU_src     <= d_ALU_src;
            e_reg_dest    <= d_reg_dest;
            e_reg_write   <= d_reg_write;
            e_branch      <= d_branch;
            e_ALU_control <= d_ALU_control;
        end
    end

    // Data half of the pipeline register: always captured; a bubble's data is
    // don't-care because none of its controls write or access memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_rd1 <= {DATA_W{1'b0}};
            e_rd2 <= {DATA_W{1'b0}};
            e_imm <= {DATA_W{1'b0}};
            e_rs  <= {REG_AW{1'b0}};
            e_rt  <= {REG_AW{1'b0}};
            e_rd  <= {REG_AW{1'b0}};
        end else begin
            e_rd1 <= d_rd1;
            e_rd2 <= d_rd2;
            e_imm <= d_imm;
            e_rs  <= d_rs;
            e_rt  <= d_rt;
            e_rd  <= d_rd;
        end
    end

    // Saturating bubble counter for performance debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= {STALL_CNT_W{1'b0}};
        end else if (count_s && (bubble_cnt != {STALL_CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt <= bubble_cnt;
        end
    end

endmodule
